// File: rtl/stb_gen_pkg.sv
// stb_gen_pkg
// Shared types and helpers for the multi-channel strobe generator.
//   mode_e   : per-channel operating mode (2-bit)
//   MODE_RST : mode loaded into every channel at reset
//   eff_div  : effective divisor, a programmed 0 behaves as 1
package stb_gen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF         = 2'd0,
        MODE_PERIODIC    = 2'd1,
        MODE_ONESHOT     = 2'd2,
        MODE_PERIODIC_DN = 2'd3
    } mode_e;

    localparam mode_e MODE_RST = MODE_PERIODIC;

    // Divisors are at most 32 bits wide; callers widen/truncate around this.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/stb_gen_ch.sv
// stb_gen_ch
// One strobe channel: prescaler, mode register and wrapping event counter.
// Ports:
//   clk, rst      : clock, async active-low reset
//   en            : run enable (level)
//   wr            : accepted config write targeting this channel
//   div/mode/clr  : config payload (divisor, mode_e, clear event counter)
//   stb           : one-cycle strobe every D enabled cycles
//   evt           : event counter, updated the cycle after stb
//   running       : channel mode is not MODE_OFF
module stb_gen_ch
    import stb_gen_pkg::*;
#(
    parameter int DIV_W       = 27,
    parameter int DIV_DEFAULT = 100_000_000,
    parameter int EVT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             stb,
    output logic [EVT_W-1:0] evt,
    output logic             running
);

    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    mode_e            r_mode, w_mode_nxt;
    logic             r_stb, w_stb_nxt;
    logic [EVT_W-1:0] r_evt, w_evt_nxt;
    logic             r_run;
    logic [DIV_W-1:0] w_dm1;
    logic             w_last;

    assign w_dm1  = DIV_W'(eff_div(32'(r_div)) - 32'd1);
    assign w_last = (r_cnt == w_dm1);

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_div_nxt  = r_div;
        w_mode_nxt = r_mode;
        w_stb_nxt  = 1'b0;
        w_evt_nxt  = r_evt;

        // Event update trails the strobe by one cycle; direction follows
        // the mode in force on the update edge.
        if (r_stb) begin
            if (r_mode == MODE_PERIODIC_DN)
                w_evt_nxt = r_evt - EVT_W'(1);
            else
                w_evt_nxt = r_evt + EVT_W'(1);
        end

        if (wr) begin
            // Config write beats a strobe due this cycle; clear beats a
            // pending event update.
            w_div_nxt  = div;
            w_mode_nxt = mode_e'(mode);
            w_cnt_nxt  = '0;
            if (clr)
                w_evt_nxt = '0;
        end else if (r_mode != MODE_OFF && en) begin
            if (w_last) begin
                w_cnt_nxt = '0;
                w_stb_nxt = 1'b1;
                if (r_mode == MODE_ONESHOT)
                    w_mode_nxt = MODE_OFF;
            end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_div  <= DIV_W'(DIV_DEFAULT);
            r_mode <= MODE_RST;
            r_stb  <= 1'b0;
            r_evt  <= '0;
            r_run  <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_div  <= w_div_nxt;
            r_mode <= w_mode_nxt;
            r_stb  <= w_stb_nxt;
            r_evt  <= w_evt_nxt;
            // Own flop so running drops on the same edge a one-shot fires.
            r_run  <= (w_mode_nxt != MODE_OFF);
        end
    end

    assign stb     = r_stb;
    assign evt     = r_evt;
    assign running = r_run;

endmodule

// File: rtl/stb_gen_multi.sv
// stb_gen_multi
// N_CH independent programmable strobe generators with a shared
// valid/ready configuration port.
// Ports:
//   clk, rst   : clock, async active-low reset
//   en         : per-channel run enable
//   cfg_valid  : config write request; cfg_ready accepts it
//   cfg_ch     : target channel (values >= N_CH are accepted and dropped)
//   cfg_div    : divisor, 0 behaves as 1
//   cfg_mode   : stb_gen_pkg::mode_e
//   cfg_clr    : clear target event counter
//   stb        : per-channel one-cycle strobes
//   evt_cnt    : packed event counters, channel i at [i*EVT_W +: EVT_W]
//   running    : per-channel mode != MODE_OFF
module stb_gen_multi
    import stb_gen_pkg::*;
#(
    parameter int  N_CH        = 4,
    parameter int  DIV_W       = 27,
    parameter int  DIV_DEFAULT = 100_000_000,
    parameter int  EVT_W       = 4,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_clr,
    output logic [N_CH-1:0]       stb,
    output logic [N_CH*EVT_W-1:0] evt_cnt,
    output logic [N_CH-1:0]       running
);

    logic            r_rdy;
    logic            w_acc;
    logic [N_CH-1:0] w_wr;

    // Ready rises on the first edge after reset release and stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rdy <= 1'b0;
        else
            r_rdy <= 1'b1;
    end

    assign cfg_ready = r_rdy;
    assign w_acc     = cfg_valid && r_rdy;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_wr[g] = w_acc && (cfg_ch == CH_W'(g));

        stb_gen_ch #(
            .DIV_W       (DIV_W),
            .DIV_DEFAULT (DIV_DEFAULT),
            .EVT_W       (EVT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .wr      (w_wr[g]),
            .div     (cfg_div),
            .mode    (cfg_mode),
            .clr     (cfg_clr),
            .stb     (stb[g]),
            .evt     (evt_cnt[g*EVT_W +: EVT_W]),
            .running (running[g])
        );
    end

endmodule

// File: tb/tb_stb_gen_multi.sv
// tb_stb_gen_multi
// Directed scenarios for stb_gen_multi (N_CH=4, DIV_W=8, DIV_DEFAULT=5,
// EVT_W=4). Stimulus pushes expected snapshots keyed by cycle number; a
// monitor pops one whenever a strobe appears or a scheduled probe is due,
// and flags any strobe that nothing expected.
module tb_stb_gen_multi;
    import stb_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_div;
    logic [1:0]  cfg_mode;
    logic        cfg_clr;
    logic [3:0]  stb;
    logic [15:0] evt_cnt;
    logic [3:0]  running;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  stb;
        logic [15:0] evt;
        logic [3:0]  run;
        logic        rdy;
    } exp_t;

    exp_t sb[$];

    stb_gen_multi #(
        .N_CH(4), .DIV_W(8), .DIV_DEFAULT(5), .EVT_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_clr   (cfg_clr),
        .stb       (stb),
        .evt_cnt   (evt_cnt),
        .running   (running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] pk(input logic [3:0] e3, input logic [3:0] e2,
                                       input logic [3:0] e1, input logic [3:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    task automatic push(input int c, input logic [3:0] s, input logic [15:0] e,
                        input logic [3:0] r);
        exp_t x;
        x.cyc = c; x.stb = s; x.evt = e; x.run = r; x.rdy = 1'b1;
        sb.push_back(x);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One-cycle write; ready is already high whenever this is used.
    task automatic cfg(input logic [1:0] ch, input logic [7:0] dv,
                       input logic [1:0] md, input logic cl);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_mode = md; cfg_clr = cl;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stb"}, 32'(stb), 32'h0);
        chk({tag, "_evt"}, 32'(evt_cnt), 32'h0);
        chk({tag, "_run"}, 32'(running), 32'hF);
        chk({tag, "_rdy"}, 32'(cfg_ready), 32'h0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    checks++; errs++;
                    $display("FAIL missed@%0d: got no sample expected stb %0h", e.cyc, e.stb);
                end
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    chk($sformatf("stb@%0d", cyc), 32'(stb), 32'(e.stb));
                    chk($sformatf("evt@%0d", cyc), 32'(evt_cnt), 32'(e.evt));
                    chk($sformatf("run@%0d", cyc), 32'(running), 32'(e.run));
                    chk($sformatf("rdy@%0d", cyc), 32'(cfg_ready), 32'(e.rdy));
                end else begin
                    chk($sformatf("idle_stb@%0d", cyc), 32'(stb), 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int c;
        logic [3:0] v;
        rst = 1'b0; en = 4'h0; cfg_valid = 1'b0; cfg_ch = 2'd0;
        cfg_div = 8'd0; cfg_mode = 2'd0; cfg_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");

        // Default divisor 5 on all channels, event counters wrap after 16.
        c = cyc; rst = 1'b1; en = 4'hF;
        push(c + 1, 4'h0, 16'h0000, 4'hF);
        for (int k = 1; k <= 17; k++) begin
            v = 4'(k - 1);
            push(c + 5 * k, 4'hF, {v, v, v, v}, 4'hF);
        end
        push(c + 86, 4'h0, 16'h1111, 4'hF);
        wait_cyc(c + 86);

        // ch2 one-shot, div 3, cleared.
        c = cyc; en = 4'b0100;
        push(c + 4,  4'b0100, pk(4'h1, 4'h0, 4'h1, 4'h1), 4'b1011);
        push(c + 5,  4'b0000, pk(4'h1, 4'h1, 4'h1, 4'h1), 4'b1011);
        push(c + 12, 4'b0000, pk(4'h1, 4'h1, 4'h1, 4'h1), 4'b1011);
        cfg(2'd2, 8'd3, MODE_ONESHOT, 1'b1);
        wait_cyc(c + 12);

        // ch1 periodic down-count, div 2, cleared.
        c = cyc; en = 4'b0010;
        push(c + 3, 4'b0010, pk(4'h1, 4'h1, 4'h0, 4'h1), 4'b1011);
        push(c + 5, 4'b0010, pk(4'h1, 4'h1, 4'hF, 4'h1), 4'b1011);
        push(c + 7, 4'b0010, pk(4'h1, 4'h1, 4'hE, 4'h1), 4'b1011);
        push(c + 8, 4'b0000, pk(4'h1, 4'h1, 4'hD, 4'h1), 4'b1011);
        cfg(2'd1, 8'd2, MODE_PERIODIC_DN, 1'b1);
        wait_cyc(c + 8);
        en = 4'b0000;

        // ch0 held at cnt 1; run to cnt 3, pause 10 cycles, resume.
        c = cyc; en = 4'b0001;
        push(c + 8,  4'b0000, pk(4'h1, 4'h1, 4'hD, 4'h1), 4'b1011);
        push(c + 14, 4'b0001, pk(4'h1, 4'h1, 4'hD, 4'h1), 4'b1011);
        push(c + 15, 4'b0000, pk(4'h1, 4'h1, 4'hD, 4'h2), 4'b1011);
        wait_cyc(c + 2);
        en = 4'b0000;
        wait_cyc(c + 12);
        en = 4'b0001;
        wait_cyc(c + 15);
        en = 4'b0000;

        // ch3 div 0 -> continuous strobe; then a write on a strobe cycle.
        c = cyc; en = 4'b1000;
        push(c + 2,  4'b1000, pk(4'h0, 4'h1, 4'hD, 4'h2), 4'b1011);
        push(c + 3,  4'b1000, pk(4'h1, 4'h1, 4'hD, 4'h2), 4'b1011);
        push(c + 4,  4'b1000, pk(4'h2, 4'h1, 4'hD, 4'h2), 4'b1011);
        push(c + 5,  4'b1000, pk(4'h3, 4'h1, 4'hD, 4'h2), 4'b1011);
        push(c + 6,  4'b0000, pk(4'h4, 4'h1, 4'hD, 4'h2), 4'b1011);
        push(c + 10, 4'b1000, pk(4'h4, 4'h1, 4'hD, 4'h2), 4'b1011);
        push(c + 11, 4'b0000, pk(4'h5, 4'h1, 4'hD, 4'h2), 4'b1011);
        cfg(2'd3, 8'd0, MODE_PERIODIC, 1'b1);
        wait_cyc(c + 5);
        cfg(2'd3, 8'd4, MODE_PERIODIC, 1'b0);
        wait_cyc(c + 11);
        en = 4'b0000;
        wait_cyc(c + 14);

        // Asynchronous reset between edges, then replay the default behaviour.
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset("rst1");
        @(negedge clk);
        c = cyc; rst = 1'b1; en = 4'hF;
        push(c + 1,  4'h0, 16'h0000, 4'hF);
        push(c + 5,  4'hF, 16'h0000, 4'hF);
        push(c + 10, 4'hF, 16'h1111, 4'hF);
        push(c + 15, 4'hF, 16'h2222, 4'hF);
        push(c + 16, 4'h0, 16'h3333, 4'hF);
        wait_cyc(c + 16);
        repeat (2) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
